// File: rtl/fma_result_writeback_if.sv
// rtl/fma_result_writeback_if.sv - rounder-side and writeback-side stream signals
interface fma_result_writeback_if #(
   parameter int PARM_EXP  = 8,
   parameter int PARM_MANT = 23,
   parameter int PARM_TAG  = 5
);
   logic                          In_valid_i;
   logic                          In_ready_o;
   logic                          Sign_result_i;
   logic [PARM_EXP-1:0]           Exp_result_i;
   logic [PARM_MANT-1:0]          Mant_result_i;
   logic                          Invalid_i;
   logic                          Overflow_i;
   logic                          Underflow_i;
   logic                          Inexact_i;
   logic [PARM_TAG-1:0]           Tag_i;
   logic                          Out_valid_o;
   logic                          Out_ready_i;
   logic [PARM_EXP+PARM_MANT:0]   Result_o;
   logic [PARM_TAG-1:0]           Tag_o;
   logic [4:0]                    Flags_o;

   modport master (
      output In_valid_i, Sign_result_i, Exp_result_i, Mant_result_i,
             Invalid_i, Overflow_i, Underflow_i, Inexact_i, Tag_i, Out_ready_i,
      input  In_ready_o, Out_valid_o, Result_o, Tag_o, Flags_o
   );

   modport slave (
      input  In_valid_i, Sign_result_i, Exp_result_i, Mant_result_i,
             Invalid_i, Overflow_i, Underflow_i, Inexact_i, Tag_i, Out_ready_i,
      output In_ready_o, Out_valid_o, Result_o, Tag_o, Flags_o
   );
endinterface

// File: rtl/fma_result_writeback.sv
// rtl/fma_result_writeback.sv - FMA result packing, fflags accumulation and 2-entry skid buffer
module fma_result_writeback #(
   parameter int                          PARM_EXP  = 8,
   parameter int                          PARM_MANT = 23,
   parameter int                          PARM_TAG  = 5,
   parameter logic [PARM_EXP+PARM_MANT:0] PARM_CNAN = 32'h7FC0_0000
) (
   input  logic                 Clk_i,
   input  logic                 Rst_n_i,
   fma_result_writeback_if.slave bus,
   input  logic                 Fflags_we_i,
   input  logic [4:0]           Fflags_wdata_i,
   output logic [4:0]           Fflags_o
);
   localparam int W = PARM_EXP + PARM_MANT + 1;

   logic [W-1:0]        word_q  [2];
   logic [PARM_TAG-1:0] tag_q   [2];
   logic [4:0]          flags_q [2];
   logic                wr_ptr;
   logic                rd_ptr;
   logic [1:0]          count;
   logic [1:0]          count_next;
   logic                in_ready_q;
   logic [4:0]          fflags_q;

   logic [4:0]          flags_in;
   logic [W-1:0]        word_in;
   logic                accept;
   logic                pop;
   logic                out_valid;

   // Raw rounder exceptions to RISC-V flag bits {NV,DZ,OF,UF,NX}; tininess only counts when inexact
   always_comb begin
      flags_in    = 5'b0;
      flags_in[4] = bus.Invalid_i;
      flags_in[3] = 1'b0;
      flags_in[2] = bus.Overflow_i;
      flags_in[1] = bus.Underflow_i & bus.Inexact_i;
      flags_in[0] = bus.Inexact_i | bus.Overflow_i;
   end

   // Pack the IEEE word; any NaN collapses to the canonical quiet NaN
   always_comb begin
      word_in = {bus.Sign_result_i, bus.Exp_result_i, bus.Mant_result_i};
      if ((&bus.Exp_result_i) && (|bus.Mant_result_i)) begin
         word_in = PARM_CNAN;
      end
   end

   assign out_valid = (count != 2'd0);
   assign accept    = bus.In_valid_i & in_ready_q;
   assign pop       = out_valid & bus.Out_ready_i;

   // Occupancy after this cycle's push/pop
   always_comb begin
      count_next = count;
      case ({accept, pop})
         2'b10:   count_next = count + 2'd1;
         2'b01:   count_next = count - 2'd1;
         default: count_next = count;
      endcase
   end

   // Buffer storage, pointers, occupancy and registered ready
   always_ff @(posedge Clk_i or negedge Rst_n_i) begin
      if (!Rst_n_i) begin
         for (int i = 0; i < 2; i++) begin
            word_q[i]  <= '0;
            tag_q[i]   <= '0;
            flags_q[i] <= '0;
         end
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
         in_ready_q <= 1'b1;
      end else begin
         if (accept) begin
            word_q[wr_ptr]  <= word_in;
            tag_q[wr_ptr]   <= bus.Tag_i;
            flags_q[wr_ptr] <= flags_in;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count      <= count_next;
         in_ready_q <= (count_next != 2'd2);
      end
   end

   // Sticky fflags: accumulate on acceptance, CSR write replaces but still merges same-cycle flags
   always_ff @(posedge Clk_i or negedge Rst_n_i) begin
      if (!Rst_n_i) begin
         fflags_q <= 5'b0;
      end else if (Fflags_we_i) begin
         fflags_q <= Fflags_wdata_i | (accept ? flags_in : 5'b0);
      end else if (accept) begin
         fflags_q <= fflags_q | flags_in;
      end
   end

   assign bus.In_ready_o  = in_ready_q;
   assign bus.Out_valid_o = out_valid;
   assign bus.Result_o    = word_q[rd_ptr];
   assign bus.Tag_o       = tag_q[rd_ptr];
   assign bus.Flags_o     = flags_q[rd_ptr];
   assign Fflags_o        = fflags_q;
endmodule

// File: tb/tb_fma_result_writeback.sv
// tb/tb_fma_result_writeback.sv - directed self-checking bench for fma_result_writeback
module tb_fma_result_writeback;
   logic       clk;
   logic       rst_n;
   logic       fflags_we;
   logic [4:0] fflags_wdata;
   logic [4:0] fflags;
   int         checks;
   int         failures;

   fma_result_writeback_if #(.PARM_EXP(8), .PARM_MANT(23), .PARM_TAG(5)) bus ();

   fma_result_writeback dut (
      .Clk_i          (clk),
      .Rst_n_i        (rst_n),
      .bus            (bus),
      .Fflags_we_i    (fflags_we),
      .Fflags_wdata_i (fflags_wdata),
      .Fflags_o       (fflags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      bus.In_valid_i    = 1'b0;
      bus.Sign_result_i = 1'b0;
      bus.Exp_result_i  = '0;
      bus.Mant_result_i = '0;
      bus.Invalid_i     = 1'b0;
      bus.Overflow_i    = 1'b0;
      bus.Underflow_i   = 1'b0;
      bus.Inexact_i     = 1'b0;
      bus.Tag_i         = '0;
   endtask

   task automatic set_inputs(input logic s, input logic [7:0] e, input logic [22:0] m,
                             input logic nv, input logic of, input logic uf, input logic nx,
                             input logic [4:0] t);
      bus.Sign_result_i = s;
      bus.Exp_result_i  = e;
      bus.Mant_result_i = m;
      bus.Invalid_i     = nv;
      bus.Overflow_i    = of;
      bus.Underflow_i   = uf;
      bus.Inexact_i     = nx;
      bus.Tag_i         = t;
      bus.In_valid_i    = 1'b1;
   endtask

   // One accepting cycle; returns #1 after the edge with inputs idle
   task automatic push(input logic s, input logic [7:0] e, input logic [22:0] m,
                       input logic nv, input logic of, input logic uf, input logic nx,
                       input logic [4:0] t);
      set_inputs(s, e, m, nv, of, uf, nx, t);
      @(posedge clk); #1;
      clear_inputs();
   endtask

   task automatic csr_write(input logic [4:0] d);
      fflags_we    = 1'b1;
      fflags_wdata = d;
      @(posedge clk); #1;
      fflags_we    = 1'b0;
      fflags_wdata = 5'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (bus.Out_valid_o !== 1'b0 || bus.Result_o !== 32'h0 || bus.Tag_o !== 5'd0 ||
          bus.Flags_o !== 5'd0 || fflags !== 5'd0) begin
         failures++;
         $display("FAIL reset_state: valid=%b result=%h tag=%0d flags=%b fflags=%b, required all zero",
                  bus.Out_valid_o, bus.Result_o, bus.Tag_o, bus.Flags_o, fflags);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.In_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_reset: got %b required 1", bus.In_ready_o);
      end
      // Buffer something with flags under back-pressure, then reset mid-stream
      bus.Out_ready_i = 1'b0;
      push(1'b0, 8'h10, 23'h1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.Out_valid_o !== 1'b0 || fflags !== 5'd0) begin
         failures++;
         $display("FAIL reset_midstream: valid=%b fflags=%b required 0/00000", bus.Out_valid_o, fflags);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.Out_ready_i = 1'b1;
      @(posedge clk); #1;
      push(1'b0, 8'h7F, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3);
      checks++;
      if (bus.Out_valid_o !== 1'b1 || bus.Result_o !== 32'h3F80_0000 || bus.Tag_o !== 5'd3 ||
          bus.Flags_o !== 5'd0) begin
         failures++;
         $display("FAIL exact_one: valid=%b result=%h tag=%0d flags=%b required 1/3f800000/3/00000",
                  bus.Out_valid_o, bus.Result_o, bus.Tag_o, bus.Flags_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_nan();
      push(1'b1, 8'hFF, 23'h40_0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4);
      checks++;
      if (bus.Result_o !== 32'h7FC0_0000 || bus.Flags_o !== 5'b10000 || fflags !== 5'b10000) begin
         failures++;
         $display("FAIL nan_canon: result=%h flags=%b fflags=%b required 7fc00000/10000/10000",
                  bus.Result_o, bus.Flags_o, fflags);
      end
      @(posedge clk); #1;
      push(1'b0, 8'hFF, 23'h1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5);
      checks++;
      if (bus.Result_o !== 32'h7FC0_0000) begin
         failures++;
         $display("FAIL nan_min_payload: result=%h required 7fc00000", bus.Result_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_underflow();
      csr_write(5'b00000);
      push(1'b0, 8'h00, 23'h12345, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6);
      checks++;
      if (bus.Flags_o !== 5'b00000 || bus.Result_o !== 32'h0001_2345) begin
         failures++;
         $display("FAIL uf_exact: flags=%b result=%h required 00000/00012345", bus.Flags_o, bus.Result_o);
      end
      @(posedge clk); #1;
      push(1'b0, 8'h00, 23'h12345, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7);
      checks++;
      if (bus.Flags_o !== 5'b00011 || fflags !== 5'b00011) begin
         failures++;
         $display("FAIL uf_inexact: flags=%b fflags=%b required 00011/00011", bus.Flags_o, fflags);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp_tag [3];
      int got;
      int first_c;
      int last_c;
      exp_tag[0] = 5'd1; exp_tag[1] = 5'd2; exp_tag[2] = 5'd3;
      bus.Out_ready_i = 1'b0;
      set_inputs(1'b0, 8'h80, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1);
      @(posedge clk); #1;
      bus.Tag_i = 5'd2;
      @(posedge clk); #1;
      checks++;
      if (bus.In_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL full_ready: got %b required 0", bus.In_ready_o);
      end
      bus.Tag_i = 5'd3;
      @(posedge clk); #1;
      checks++;
      if (bus.In_ready_o !== 1'b0 || bus.Out_valid_o !== 1'b1 || bus.Tag_o !== 5'd1 ||
          bus.Result_o !== 32'h4000_0000) begin
         failures++;
         $display("FAIL stall_hold: ready=%b valid=%b tag=%0d result=%h required 0/1/1/40000000",
                  bus.In_ready_o, bus.Out_valid_o, bus.Tag_o, bus.Result_o);
      end
      bus.Out_ready_i = 1'b1;
      got = 0;
      first_c = -1;
      last_c = -1;
      for (int c = 0; c < 12 && got < 3; c++) begin
         logic acc;
         acc = bus.In_valid_i & bus.In_ready_o;
         if (bus.Out_valid_o && bus.Out_ready_i) begin
            checks++;
            if (bus.Tag_o !== exp_tag[got]) begin
               failures++;
               $display("FAIL order_%0d: tag=%0d required %0d", got, bus.Tag_o, exp_tag[got]);
            end
            if (first_c < 0) first_c = c;
            last_c = c;
            got++;
         end
         @(posedge clk); #1;
         if (acc) clear_inputs();
      end
      checks++;
      if (got != 3 || (last_c - first_c) != 2) begin
         failures++;
         $display("FAIL drain: handshakes=%0d span=%0d required 3/2", got, last_c - first_c);
      end
      clear_inputs();
      @(posedge clk); #1;
   endtask

   task automatic test_csr();
      csr_write(5'b01010);
      checks++;
      if (fflags !== 5'b01010) begin
         failures++;
         $display("FAIL csr_write: fflags=%b required 01010", fflags);
      end
      csr_write(5'b00001);
      fflags_we    = 1'b1;
      fflags_wdata = 5'b00000;
      push(1'b0, 8'hFF, 23'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8);
      fflags_we = 1'b0;
      checks++;
      if (fflags !== 5'b00101) begin
         failures++;
         $display("FAIL csr_collision: fflags=%b required 00101", fflags);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_overflow();
      push(1'b0, 8'hFF, 23'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10);
      checks++;
      if (bus.Result_o !== 32'h7F80_0000 || bus.Flags_o !== 5'b00101 || bus.Tag_o !== 5'd10) begin
         failures++;
         $display("FAIL overflow_inf: result=%h flags=%b tag=%0d required 7f800000/00101/10",
                  bus.Result_o, bus.Flags_o, bus.Tag_o);
      end
      @(posedge clk); #1;
      push(1'b1, 8'h00, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd11);
      checks++;
      if (bus.Result_o !== 32'h8000_0000 || bus.Flags_o !== 5'b00000) begin
         failures++;
         $display("FAIL neg_zero: result=%h flags=%b required 80000000/00000", bus.Result_o, bus.Flags_o);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.Out_valid_o !== 1'b0 || bus.In_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL idle_end: valid=%b ready=%b required 0/1", bus.Out_valid_o, bus.In_ready_o);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      fflags_we = 1'b0;
      fflags_wdata = 5'b0;
      bus.Out_ready_i = 1'b1;
      clear_inputs();
      #12;
      test_reset();
      test_nan();
      test_underflow();
      test_back_to_back();
      test_csr();
      test_overflow();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fma_result_writeback.md
Name: fma_result_writeback

Overview:
- Stage directly downstream of the FMA rounder; registers the rounder's sign/exponent/mantissa and exception outputs.
- Packs them into an IEEE-754 word and canonicalises NaNs.
- Converts raw exception outputs into RISC-V fflags semantics and accumulates them into a sticky fflags register.
- Presents the result to the register-file writeback through a 2-entry valid/ready skid buffer, so writeback back-pressure never drops a rounded result.

Parameters:
- PARM_EXP, 8: exponent width.
- PARM_MANT, 23: stored mantissa width (no hidden bit).
- PARM_TAG, 5: destination-register tag width.
- PARM_CNAN, 32'h7FC0_0000: canonical NaN word.

Ports:
- Clk_i  input  1  clock; all state updates on rising edge.
- Rst_n_i  input  1  asynchronous active-low reset.
- In_valid_i  input  1  rounder result valid.
- In_ready_o  output  1  stage can accept a result.
- Sign_result_i  input  1  rounded sign.
- Exp_result_i  input  PARM_EXP  rounded exponent.
- Mant_result_i  input  PARM_MANT  rounded mantissa.
- Invalid_i  input  1  invalid-operation flag.
- Overflow_i  input  1  overflow flag.
- Underflow_i  input  1  underflow flag (raw; may be set on exact denormals).
- Inexact_i  input  1  inexact flag.
- Tag_i  input  PARM_TAG  destination tag travelling with the result.
- Out_valid_o  output  1  packed result valid.
- Out_ready_i  input  1  writeback accepts result.
- Result_o  output  PARM_EXP+PARM_MANT+1  packed word {sign, exp, mant}.
- Tag_o  output  PARM_TAG  destination tag.
- Flags_o  output  5  per-result flags {NV,DZ,OF,UF,NX}.
- Fflags_we_i  input  1  CSR write strobe for accumulated fflags.
- Fflags_wdata_i  input  5  CSR write data.
- Fflags_o  output  5  accumulated sticky fflags.

Behaviour:
- Reset (asynchronous, Rst_n_i=0), immediately on assertion:
  - both buffer entries invalid; count=0.
  - Out_valid_o=0, Result_o=0, Tag_o=0, Flags_o=0, Fflags_o=0.
  - In_ready_o=1 once reset is released.
- Reset mid-operation discards buffered results; no flags are accumulated for them.
- Flag conversion (combinational, on input side):
  - NV=Invalid_i; DZ=0 always; OF=Overflow_i.
  - UF=Underflow_i & Inexact_i (tininess is reported only when inexact).
  - NX=Inexact_i | Overflow_i.
- Packing: word={Sign_result_i, Exp_result_i, Mant_result_i}.
  - If Exp_result_i is all-ones and Mant_result_i≠0, word=PARM_CNAN regardless of sign.
  - Infinity and zero are passed unchanged, sign included.
- Buffer: 2 entries, FIFO order, each entry holding {word, tag, flags}.
  - In_ready_o = (count<2); registered, not combinationally dependent on Out_ready_i.
  - Accept on In_valid_i & In_ready_o.
  - Pop on Out_valid_o & Out_ready_i.
  - Latency 1 cycle: a result accepted at edge N is visible with Out_valid_o=1 after edge N.
  - Push and pop in the same cycle: count unchanged, order preserved.
    - At count=2, In_ready_o=0, so no push is possible.
    - Pop at count=2 raises In_ready_o the next cycle.
  - Outputs hold stable while Out_valid_o=1 & Out_ready_i=0.
  - Throughput is 1 result/cycle while Out_ready_i=1.
- Fflags accumulation: happens on input acceptance, not on output pop.
  - Accept only: Fflags_next = Fflags_o | flags_in.
  - Fflags_we_i only: Fflags_next = Fflags_wdata_i.
  - Both in the same cycle: Fflags_next = Fflags_wdata_i | flags_in.
  - Neither: hold.
- Counter widths: count is 2 bits; read/write pointers are 1 bit and wrap naturally.

Test Plan:
- Reset/exact result: assert Rst_n_i low mid-stream -> Out_valid_o=0 and Fflags_o=0 immediately. After release, push sign=0, exp=8'h7F, mant=0, no flags, Tag=3 -> next cycle Result_o=32'h3F80_0000, Tag_o=3, Flags_o=0.
- NaN canonicalisation: push sign=1, exp=8'hFF, mant=23'h40_0000, Invalid=1 -> Result_o=32'h7FC0_0000, Flags_o=5'b10000, Fflags_o=5'b10000.
- Underflow masking: push an exact denormal (Underflow=1, Inexact=0) -> Flags_o=0. Then push Underflow=1, Inexact=1 -> Flags_o=5'b00011 and Fflags_o=5'b00011.
- Back-pressure: hold Out_ready_i=0 and push tags 1,2,3 -> accepts 1,2; In_ready_o=0 at count=2; tag 3 stalls. Release Out_ready_i -> tags emitted 1,2,3 in order on consecutive handshakes, none lost.
- CSR collision: Fflags_o=5'b00001, then in one cycle Fflags_we_i=1 with wdata=0 and accept a result with OF=1 (NX=1) -> Fflags_o=5'b00101.
- Overflow pass-through: push sign=0, exp=8'hFF, mant=0, Overflow=1 -> Result_o=32'h7F80_0000, Flags_o=5'b00101.
